// File: rtl/mem_queue_write_arbiter.sv
// Round-robin arbiter sharing the mem-queue write port and the mem_size
// report port among N SMEM lanes. Keeps a per-read slot pointer so each
// MEM record lands at read_num*READ_MAX_MEM+slot, and sequences a batch
// (pointer clear sweep, collect, done once batch_size reads have ended).
module mem_queue_write_arbiter #(
  parameter int N_LANES        = 4,
  parameter int READ_NUM_WIDTH = 6,
  parameter int READ_MAX_MEM   = 40,
  parameter int DATA_W         = 256,
  parameter int SZ_W           = 7
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               batch_start,
  input  logic [READ_NUM_WIDTH:0]            batch_size,
  input  logic                               stall,
  input  logic [N_LANES-1:0]                 req,
  input  logic [N_LANES-1:0]                 req_end,
  input  logic [N_LANES*READ_NUM_WIDTH-1:0]  req_read_num,
  input  logic [N_LANES*DATA_W-1:0]          req_data,
  output logic [N_LANES-1:0]                 gnt,
  output logic                               mem_we_1,
  output logic [READ_NUM_WIDTH-1:0]          mem_read_num_1,
  output logic [SZ_W-1:0]                    mem_addr_1,
  output logic [DATA_W-1:0]                  mem_data_1,
  output logic                               mem_size_valid,
  output logic [SZ_W-1:0]                    mem_size,
  output logic [READ_NUM_WIDTH-1:0]          mem_size_read_num,
  output logic                               batch_done,
  output logic                               overflow
);
  localparam int MAX_READ = 1 << READ_NUM_WIDTH;
  localparam int LW       = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t                      r_state;
  logic [LW-1:0]               r_rr_ptr;
  logic [READ_NUM_WIDTH-1:0]   r_clr_idx;
  logic [READ_NUM_WIDTH:0]     r_end_cnt;
  logic [READ_NUM_WIDTH:0]     r_bsize;
  logic [SZ_W-1:0]             r_cnt [MAX_READ];

  logic                        w_found;
  logic [LW-1:0]               w_sel;
  logic [LW-1:0]               w_cand;
  logic [N_LANES-1:0]          w_gnt;
  logic [READ_NUM_WIDTH-1:0]   w_rn;
  logic [SZ_W-1:0]             w_ptr;
  logic                        w_ptr_ok;
  logic                        w_is_end;
  logic [DATA_W-1:0]           w_data;
  logic [LW-1:0]               w_rr_nxt;
  logic                        w_start_ok;

  // Pick the first requesting lane at or after rr_ptr; nothing granted
  // while stalled, outside RUN, or while reset is being applied.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    w_gnt   = '0;
    if (r_state == RUN && !stall && !reset) begin
      for (int k = 0; k < N_LANES; k++) begin
        w_cand = LW'((int'(r_rr_ptr) + k) % N_LANES);
        if (!w_found && req[w_cand]) begin
          w_found = 1'b1;
          w_sel   = w_cand;
        end
      end
    end
    w_gnt[w_sel] = w_found;
  end

  assign gnt        = w_gnt;
  assign w_rn       = req_read_num[w_sel*READ_NUM_WIDTH +: READ_NUM_WIDTH];
  assign w_data     = req_data[w_sel*DATA_W +: DATA_W];
  assign w_is_end   = req_end[w_sel];
  // Pointer array is flops read combinationally: back-to-back beats to
  // one read see the already-advanced pointer.
  assign w_ptr      = r_cnt[w_rn];
  assign w_ptr_ok   = (w_ptr < SZ_W'(READ_MAX_MEM));
  assign w_rr_nxt   = (int'(w_sel) == N_LANES-1) ? '0 : w_sel + 1'b1;
  assign w_start_ok = batch_start && (r_state == IDLE || r_state == DONE);

  // Per-read slot pointers: zeroed one per cycle by the CLEAR sweep,
  // advanced on each accepted data beat; deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR)
        r_cnt[r_clr_idx] <= '0;
      else if (w_found && !w_is_end && w_ptr_ok)
        r_cnt[w_rn] <= w_ptr + 1'b1;
    end
  end

  // Batch FSM, round-robin pointer and registered RAM/report port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_rr_ptr          <= '0;
      r_clr_idx         <= '0;
      r_end_cnt         <= '0;
      r_bsize           <= '0;
      mem_we_1          <= 1'b0;
      mem_read_num_1    <= '0;
      mem_addr_1        <= '0;
      mem_data_1        <= '0;
      mem_size_valid    <= 1'b0;
      mem_size          <= '0;
      mem_size_read_num <= '0;
      batch_done        <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      mem_we_1       <= 1'b0;
      mem_size_valid <= 1'b0;

      if (w_found) begin
        r_rr_ptr <= w_rr_nxt;
        if (w_is_end) begin
          mem_size_valid    <= 1'b1;
          mem_size          <= w_ptr;
          mem_size_read_num <= w_rn;
          r_end_cnt         <= r_end_cnt + 1'b1;
        end else if (w_ptr_ok) begin
          mem_we_1       <= 1'b1;
          mem_addr_1     <= w_ptr;
          mem_read_num_1 <= w_rn;
          mem_data_1     <= w_data;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (w_start_ok) begin
        r_state    <= CLEAR;
        r_clr_idx  <= '0;
        r_end_cnt  <= '0;
        r_bsize    <= batch_size;
        overflow   <= 1'b0;
        batch_done <= 1'b0;
      end else begin
        case (r_state)
          CLEAR: begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == READ_NUM_WIDTH'(MAX_READ-1)) begin
              r_state    <= (r_bsize != '0) ? RUN : DONE;
              batch_done <= (r_bsize == '0);
            end
          end
          RUN: begin
            if (r_end_cnt == r_bsize) begin
              r_state    <= DONE;
              batch_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_queue_write_arbiter.sv
// Directed bench for mem_queue_write_arbiter: batch sequencing, slot
// placement, round-robin order, saturation, stall and reset-mid-batch.
module tb_mem_queue_write_arbiter;
  logic         clk = 1'b0;
  logic         reset, batch_start, stall;
  logic [6:0]   batch_size;
  logic [3:0]   req, req_end, gnt;
  logic [23:0]  req_read_num;
  logic [1023:0] req_data;
  logic         mem_we_1, mem_size_valid, batch_done, overflow;
  logic [5:0]   mem_read_num_1, mem_size_read_num;
  logic [6:0]   mem_addr_1, mem_size;
  logic [255:0] mem_data_1;

  int n_vec = 0;
  int n_err = 0;
  int itm [4];

  mem_queue_write_arbiter dut (
    .clk(clk), .reset(reset), .batch_start(batch_start), .batch_size(batch_size),
    .stall(stall), .req(req), .req_end(req_end), .req_read_num(req_read_num),
    .req_data(req_data), .gnt(gnt), .mem_we_1(mem_we_1),
    .mem_read_num_1(mem_read_num_1), .mem_addr_1(mem_addr_1), .mem_data_1(mem_data_1),
    .mem_size_valid(mem_size_valid), .mem_size(mem_size),
    .mem_size_read_num(mem_size_read_num), .batch_done(batch_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] mk(input int l, input int k);
    return {4{64'(l * 256 + k + 1)}};
  endfunction

  task automatic start_batch(input logic [6:0] sz);
    batch_start = 1'b1; batch_size = sz;
    step();
    batch_start = 1'b0;
    repeat (64) step();
  endtask

  // One transfer on lane ln; checks the grant, then the registered strobe.
  task automatic beat(input int ln, input bit e, input logic [5:0] rn, input logic [255:0] d,
                      input bit exp_wr, input logic [6:0] exp_v);
    int t;
    req = '0; req[ln] = 1'b1; req_end[ln] = e;
    req_read_num[ln*6 +: 6] = rn; req_data[ln*256 +: 256] = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (gnt[ln] || t >= 20) break;
      t++;
    end
    chk("gnt", gnt, 256'(4'b1 << ln));
    step();
    req = '0;
    if (e) begin
      chk("size_vld", mem_size_valid, 1);
      chk("mem_size", mem_size, exp_v);
      chk("size_rn", mem_size_read_num, rn);
    end else if (exp_wr) begin
      chk("we", mem_we_1, 1);
      chk("addr", mem_addr_1, exp_v);
      chk("wr_rn", mem_read_num_1, rn);
      chk("data", mem_data_1, d);
    end else begin
      chk("we_sat", mem_we_1, 0);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10 && !batch_done; i++) step();
    chk("done", batch_done, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; batch_start = 1'b0; batch_size = '0; stall = 1'b0;
    req = '0; req_end = '0; req_read_num = '0; req_data = '0;
    step(); step();
    // 1: reset state, then single read of 3 beats
    chk("rst_we", mem_we_1, 0);
    chk("rst_sv", mem_size_valid, 0);
    chk("rst_done", batch_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_data", mem_data_1, 0);
    reset = 1'b0;
    start_batch(7'd1);
    for (int k = 0; k < 3; k++) beat(0, 0, 6'd5, mk(0, k), 1, 7'(k));
    beat(0, 1, 6'd5, '0, 0, 7'd3);
    wait_done();

    // 2: four lanes requesting continuously from rr_ptr=0
    do_reset();
    start_batch(7'd4);
    for (int l = 0; l < 4; l++) itm[l] = 0;
    for (int c = 0; c < 12; c++) begin
      int l, k;
      for (int j = 0; j < 4; j++) begin
        req[j] = (itm[j] < 3);
        req_end[j] = (itm[j] == 2);
        req_read_num[j*6 +: 6] = 6'(10 + j);
        req_data[j*256 +: 256] = mk(j, itm[j]);
      end
      l = c % 4; k = c / 4;
      @(negedge clk);
      chk("rr_gnt", gnt, 256'(4'b1 << l));
      step();
      itm[l]++;
      if (k < 2) begin
        chk("rr_we", mem_we_1, 1);
        chk("rr_addr", mem_addr_1, 7'(k));
        chk("rr_rn", mem_read_num_1, 6'(10 + l));
        chk("rr_data", mem_data_1, mk(l, k));
      end else begin
        chk("rr_sv", mem_size_valid, 1);
        chk("rr_size", mem_size, 7'd2);
      end
    end
    req = '0;
    wait_done();

    // 3: saturation of read 7 at 40 slots
    start_batch(7'd1);
    chk("clr_done", batch_done, 0);
    for (int k = 0; k < 41; k++) beat(1, 0, 6'd7, mk(1, k), k < 40, 7'(k));
    chk("ovf", overflow, 1);
    beat(1, 1, 6'd7, '0, 0, 7'd40);
    wait_done();

    // 4: stall holds grants; rr_ptr=2 so lane 3 wins over lane 0 on release
    start_batch(7'd2);
    chk("ovf_clr", overflow, 0);
    stall = 1'b1;
    req = 4'b1001; req_end = '0;
    req_read_num[0 +: 6] = 6'd20; req_read_num[18 +: 6] = 6'd21;
    req_data[0 +: 256] = mk(0, 9); req_data[768 +: 256] = mk(3, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stl_gnt", gnt, 0);
      chk("stl_we", mem_we_1, 0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("rel_gnt", gnt, 4'b1000);
    step();
    req[3] = 1'b0;
    chk("rel_we", mem_we_1, 1);
    chk("rel_rn", mem_read_num_1, 6'd21);
    chk("rel_addr", mem_addr_1, 0);
    @(negedge clk);
    chk("rel_gnt2", gnt, 4'b0001);
    step();
    req = '0;
    chk("rel_rn2", mem_read_num_1, 6'd20);
    chk("rel_data2", mem_data_1, mk(0, 9));
    beat(0, 1, 6'd20, '0, 0, 7'd1);
    beat(3, 1, 6'd21, '0, 0, 7'd1);
    wait_done();

    // 5: empty batch, then batch_start during RUN ignored
    batch_start = 1'b1; batch_size = 7'd0;
    step();
    batch_start = 1'b0;
    chk("b0_clr", batch_done, 0);
    repeat (64) step();
    chk("b0_done", batch_done, 1);
    chk("b0_sv", mem_size_valid, 0);
    start_batch(7'd1);
    batch_start = 1'b1; batch_size = 7'd5;
    step();
    batch_start = 1'b0;
    beat(2, 0, 6'd5, mk(2, 0), 1, 7'd0);
    beat(2, 1, 6'd5, '0, 0, 7'd1);
    wait_done();

    // 6: reset mid-RUN, then a fresh batch restarts read 5 at slot 0
    start_batch(7'd2);
    beat(0, 0, 6'd5, mk(0, 0), 1, 7'd0);
    beat(0, 0, 6'd5, mk(0, 1), 1, 7'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_we", mem_we_1, 0);
    chk("mr_addr", mem_addr_1, 0);
    chk("mr_done", batch_done, 0);
    start_batch(7'd1);
    beat(0, 0, 6'd5, mk(0, 2), 1, 7'd0);
    beat(0, 1, 6'd5, '0, 0, 7'd1);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
